// File: rtl/atomic_clock_sequencer.sv
// -----------------------------------------------------------------------------
// atomic_clock_sequencer
//
// Programmable 10-phase timing sequencer for the atomic-clock cycle (Q0..Q9).
// A single dwell counter times every phase against a host-writable dwell
// table. Supports start/stop/pause, single-shot or continuous looping, and
// counts completed Q9 phases since the last start.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        level; starts a sequence when idle (ignored if stop is high)
//   stop         level; aborts the sequence, highest priority
//   pause        level; freezes counter and phase while high
//   continuous   1 = loop Q9->Q0, 0 = single shot; sampled at the end of Q9
//   cfg_we       dwell-table write strobe (accepted only while idle)
//   cfg_addr     phase index to write
//   cfg_data     dwell value in clk cycles (0 behaves as 1)
//   phase        current phase code
//   phase_start  one-cycle pulse on the first cycle of every phase
//   running      high while RUN or PAUSED
//   seq_done     one-cycle pulse when a single-shot sequence completes
//   cycle_count  completed Q9 phases since the last start (wraps)
//   cfg_err      one-cycle pulse after a rejected config write
// -----------------------------------------------------------------------------
module atomic_clock_sequencer #(
  parameter int N_PHASES = 10,
  parameter int DUR_W    = 26,
  parameter int CYC_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             continuous,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [DUR_W-1:0] cfg_data,
  output logic [3:0]       phase,
  output logic             phase_start,
  output logic             running,
  output logic             seq_done,
  output logic [CYC_W-1:0] cycle_count,
  output logic             cfg_err
);

  localparam int PH_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED
  } state_t;

  // Power-on dwell values, restored on every reset.
  function automatic logic [DUR_W-1:0] default_dur(input int idx);
    case (idx)
      0:       return DUR_W'(20000);
      1:       return DUR_W'(50000);
      2:       return DUR_W'(60000000);
      3:       return DUR_W'(250000);
      4:       return DUR_W'(30000000);
      5:       return DUR_W'(630000);
      6:       return DUR_W'(1840000);
      7:       return DUR_W'(1890000);
      8:       return DUR_W'(950000);
      9:       return DUR_W'(1200000);
      default: return DUR_W'(1);
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [DUR_W-1:0] cnt_q, cnt_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             phase_start_q, phase_start_d;
  logic             running_q, running_d;
  logic             seq_done_q, seq_done_d;
  logic             cfg_err_q, cfg_err_d;
  logic [DUR_W-1:0] dur_q [N_PHASES];

  logic [DUR_W-1:0] dwell;
  logic [DUR_W-1:0] last_cnt;
  logic             last_cycle;
  logic             cfg_ok;

  // A zero dwell is forced to one cycle, so the terminal count is never
  // below zero and the counter can never wrap.
  assign dwell      = dur_q[phase_q];
  assign last_cnt   = (dwell == '0) ? '0 : dwell - DUR_W'(1);
  assign last_cycle = (cnt_q == last_cnt);

  // The table only changes while idle, so a running sequence never sees
  // a dwell change mid-flight.
  assign cfg_ok = cfg_we && (state_q == S_IDLE) && (cfg_addr < PH_W'(N_PHASES));

  // NOTE: every signal assigned here gets a default first; without it any
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    cyc_d         = cyc_q;
    phase_start_d = 1'b0;
    seq_done_d    = 1'b0;
    cfg_err_d     = cfg_we && !cfg_ok;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d       = S_RUN;
          phase_d       = '0;
          cnt_d         = '0;
          cyc_d         = '0;
          phase_start_d = 1'b1;
        end
      end

      S_RUN, S_PAUSED: begin
        if (stop) begin
          // Abort: no seq_done, cycle_count keeps its value.
          state_d = S_IDLE;
          phase_d = '0;
          cnt_d   = '0;
        end else if (pause) begin
          // Hold everything, including a pending end-of-phase advance.
          state_d = S_PAUSED;
        end else begin
          // Resuming from PAUSED counts on the same cycle pause drops, so a
          // pause of N cycles stretches the phase by exactly N cycles.
          state_d = S_RUN;
          if (!last_cycle) begin
            cnt_d = cnt_q + DUR_W'(1);
          end else begin
            cnt_d = '0;
            if (phase_q == PH_W'(N_PHASES - 1)) begin
              cyc_d = cyc_q + CYC_W'(1);
              phase_d = '0;
              if (continuous) begin
                phase_start_d = 1'b1;
              end else begin
                state_d    = S_IDLE;
                seq_done_d = 1'b1;
              end
            end else begin
              phase_d       = phase_q + PH_W'(1);
              phase_start_d = 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign running_d = (state_d != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      cnt_q         <= '0;
      cyc_q         <= '0;
      phase_start_q <= 1'b0;
      running_q     <= 1'b0;
      seq_done_q    <= 1'b0;
      cfg_err_q     <= 1'b0;
      // NOTE: the dwell table is a small register file with defined power-on
      // contents, so it is deliberately reset (unlike a RAM, which is not).
      for (int i = 0; i < N_PHASES; i++) begin
        dur_q[i] <= default_dur(i);
      end
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      cyc_q         <= cyc_d;
      phase_start_q <= phase_start_d;
      running_q     <= running_d;
      seq_done_q    <= seq_done_d;
      cfg_err_q     <= cfg_err_d;
      if (cfg_ok) begin
        dur_q[cfg_addr] <= cfg_data;
      end
    end
  end

  assign phase       = phase_q;
  assign phase_start = phase_start_q;
  assign running     = running_q;
  assign seq_done    = seq_done_q;
  assign cycle_count = cyc_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_atomic_clock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_atomic_clock_sequencer
//
// Directed bench for atomic_clock_sequencer. Each started sequence pushes its
// expected phase_start / seq_done events (kind, phase, absolute cycle) into a
// scoreboard queue; a negedge monitor pops and compares every event the DUT
// produces and checks that phase holds steady between events.
// -----------------------------------------------------------------------------
module tb_atomic_clock_sequencer;

  localparam int N  = 10;
  localparam int DW = 26;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          continuous = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [3:0]    phase;
  logic          phase_start;
  logic          running;
  logic          seq_done;
  logic [CW-1:0] cycle_count;
  logic          cfg_err;

  atomic_clock_sequencer #(.N_PHASES(N), .DUR_W(DW), .CYC_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .continuous  (continuous),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .phase       (phase),
    .phase_start (phase_start),
    .running     (running),
    .seq_done    (seq_done),
    .cycle_count (cycle_count),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_e;
  logic [3:0]  cur_ph = '0;
  int          dw [N];
  int          b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Event encoding: {is_seq_done, phase, cycle}.
  function automatic logic [31:0] ev(input bit done, input int ph, input int t);
    return {done, 4'(ph), 27'(t)};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (phase_start || seq_done) begin
        check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_e = sb.pop_front();
          check(phase_start ? "phase_start_evt" : "seq_done_evt",
                ev(seq_done, int'(phase), cyc), exp_e);
          if (!exp_e[31]) cur_ph = exp_e[30:27];
        end
      end
      if (running) check("phase_hold", 32'(phase), 32'(cur_ph));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = DW'(d);
    step();
    cfg_we   = 1'b0;
  endtask

  // Drives start for one cycle; returns the cycle of the first phase_start.
  task automatic do_start(output int base);
    start = 1'b1;
    base  = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic push_seq(input int base, input int loops, input bit done);
    int t;
    t = base;
    for (int l = 0; l < loops; l++) begin
      for (int k = 0; k < N; k++) begin
        sb.push_back(ev(1'b0, k, t));
        t += (dw[k] < 1) ? 1 : dw[k];
      end
    end
    if (done) sb.push_back(ev(1'b1, 0, t));
  endtask

  initial begin
    // ---- reset values
    step();
    step();
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_phase_start", 32'(phase_start), 32'd0);
    check("rst_seq_done", 32'(seq_done), 32'd0);
    check("rst_cycle_count", 32'(cycle_count), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    step();

    // ---- 1: single shot, all dwells 3
    for (int k = 0; k < N; k++) begin
      cfg_write(k, 3);
      dw[k] = 3;
    end
    do_start(b);
    push_seq(b, 1, 1'b1);
    goto(b + 15);
    check("t1_mid_phase", 32'(phase), 32'd5);
    goto(b + 30);
    check("t1_seq_done", 32'(seq_done), 32'd1);
    check("t1_running", 32'(running), 32'd0);
    check("t1_cycle_count", 32'(cycle_count), 32'd1);
    check("t1_phase", 32'(phase), 32'd0);
    step();
    check("t1_done_pulse", 32'(seq_done), 32'd0);

    // ---- 2: continuous, dwells 2, three full loops
    for (int k = 0; k < N; k++) begin
      cfg_write(k, 2);
      dw[k] = 2;
    end
    continuous = 1'b1;
    do_start(b);
    push_seq(b, 3, 1'b0);
    sb.push_back(ev(1'b0, 0, b + 60));
    goto(b + 59);
    check("t2_count_before", 32'(cycle_count), 32'd2);
    goto(b + 60);
    check("t2_count_3", 32'(cycle_count), 32'd3);
    check("t2_wrap_phase", 32'(phase), 32'd0);
    check("t2_running", 32'(running), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    continuous = 1'b0;
    check("t2_stop_running", 32'(running), 32'd0);
    check("t2_count_hold", 32'(cycle_count), 32'd3);
    check("t2_no_done", 32'(seq_done), 32'd0);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // ---- 3: pause 4 cycles at count 1 of phase 2, then stop in phase 4
    for (int k = 0; k < N; k++) begin
      cfg_write(k, 5);
      dw[k] = 5;
    end
    do_start(b);
    sb.push_back(ev(1'b0, 0, b));
    sb.push_back(ev(1'b0, 1, b + 5));
    sb.push_back(ev(1'b0, 2, b + 10));
    sb.push_back(ev(1'b0, 3, b + 19));
    sb.push_back(ev(1'b0, 4, b + 24));
    goto(b + 11);
    pause = 1'b1;
    goto(b + 13);
    check("t3_paused_running", 32'(running), 32'd1);
    check("t3_paused_phase", 32'(phase), 32'd2);
    goto(b + 15);
    pause = 1'b0;
    goto(b + 25);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t3_stop_phase", 32'(phase), 32'd0);
    check("t3_stop_running", 32'(running), 32'd0);
    check("t3_stop_no_done", 32'(seq_done), 32'd0);
    check("t3_stop_no_ps", 32'(phase_start), 32'd0);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // ---- 4: config rules
    cfg_write(12, 1);
    check("t4_bad_addr_err", 32'(cfg_err), 32'd1);
    step();
    check("t4_err_pulse", 32'(cfg_err), 32'd0);
    do_start(b);
    push_seq(b, 1, 1'b1);
    goto(b + 6);
    cfg_write(3, 1);
    check("t4_busy_err", 32'(cfg_err), 32'd1);
    goto(b + 50);
    check("t4_done_old_dwell", 32'(seq_done), 32'd1);
    step();
    cfg_write(3, 0);
    dw[3] = 0;
    check("t4_good_write_no_err", 32'(cfg_err), 32'd0);
    do_start(b);
    push_seq(b, 1, 1'b1);
    goto(b + 15);
    check("t4_zero_dwell_phase", 32'(phase), 32'd3);
    step();
    check("t4_zero_dwell_next", 32'(phase), 32'd4);
    goto(b + 46);
    check("t4_zero_dwell_done", 32'(seq_done), 32'd1);
    step();

    // ---- 5: simultaneous events
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("t5_start_stop_idle", 32'(running), 32'd0);
    check("t5_start_stop_no_ps", 32'(phase_start), 32'd0);
    do_start(b);
    push_seq(b, 1, 1'b0);
    goto(b + 45);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t5_q9_stop_running", 32'(running), 32'd0);
    check("t5_q9_stop_no_done", 32'(seq_done), 32'd0);
    check("t5_q9_stop_count", 32'(cycle_count), 32'd0);
    check("t5_q9_stop_phase", 32'(phase), 32'd0);
    step();
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // ---- 6: async reset in phase 6 of the second loop
    continuous = 1'b1;
    do_start(b);
    push_seq(b, 1, 1'b0);
    for (int k = 0; k < 7; k++) sb.push_back(ev(1'b0, k, b + 46 + ((k < 4) ? 5 * k : 5 * k - 4)));
    goto(b + 74);
    check("t6_pre_count", 32'(cycle_count), 32'd1);
    check("t6_pre_phase", 32'(phase), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_phase", 32'(phase), 32'd0);
    check("t6_rst_running", 32'(running), 32'd0);
    check("t6_rst_phase_start", 32'(phase_start), 32'd0);
    check("t6_rst_seq_done", 32'(seq_done), 32'd0);
    check("t6_rst_cycle_count", 32'(cycle_count), 32'd0);
    check("t6_rst_cfg_err", 32'(cfg_err), 32'd0);
    check("t6_sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    continuous = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    // Defaults restored: phase 0 must now dwell 20000 cycles.
    do_start(b);
    sb.push_back(ev(1'b0, 0, b));
    sb.push_back(ev(1'b0, 1, b + 20000));
    goto(b + 19999);
    check("t6_default_q0_hold", 32'(phase), 32'd0);
    goto(b + 20000);
    check("t6_default_q1", 32'(phase), 32'd1);
    check("t6_default_q1_ps", 32'(phase_start), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t6_final_idle", 32'(running), 32'd0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/atomic_clock_sequencer.md
Name: atomic_clock_sequencer

Overview:
- Programmable 10-phase timing sequencer for the atomic-clock cycle (phases Q0..Q9); owns the per-phase dwell table and the dwell counter, and drives the current phase code to the downstream output decoders.
- Replaces free-running per-phase compare logic with one counter, start/stop/pause control, single-shot or continuous mode, and a completed-cycle counter.
- Dwell table is writable from the host config port while idle.

Parameters:
- N_PHASES, 10, number of phases; phase codes 0..N_PHASES-1.
- DUR_W, 26, dwell width in clk cycles; max dwell 2^26-1.
- CYC_W, 16, completed-cycle counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level, sampled each cycle; starts a sequence when idle.
- stop  in  1  level; aborts the sequence.
- pause  in  1  level; freezes the dwell counter while high.
- continuous  in  1  1 = loop Q9->Q0; 0 = single shot. Sampled at the end of Q9.
- cfg_we  in  1  dwell-table write strobe.
- cfg_addr  in  4  phase index to write.
- cfg_data  in  DUR_W  dwell value in clk cycles.
- phase  out  4  current phase code.
- phase_start  out  1  one-cycle pulse on the first cycle of every phase.
- running  out  1  high while in RUN or PAUSED.
- seq_done  out  1  one-cycle pulse when a single-shot sequence completes.
- cycle_count  out  CYC_W  number of completed Q9 phases since the last start.
- cfg_err  out  1  one-cycle pulse on a rejected config write.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, phase=0, dwell counter=0; running, phase_start, seq_done, cfg_err=0; cycle_count=0.
  - Dwell table reloads defaults: 20000, 50000, 60000000, 250000, 30000000, 630000, 1840000, 1890000, 950000, 1200000 for phases 0..9.
  - Reset mid-sequence aborts immediately; no seq_done.
- FSM states: IDLE, RUN, PAUSED. All outputs are registered.
- IDLE -> RUN when start=1 and stop=0. On the next edge: running=1, phase=0, phase_start=1, counter=0, cycle_count=0.
- RUN:
  - Counter increments each cycle.
  - Phase k lasts exactly max(dur[k],1) cycles, counted from its phase_start cycle. A dwell of 0 is treated as 1.
  - On the last cycle of phase k<9: the next edge sets phase=k+1, counter=0, phase_start=1.
- End of Q9 (last cycle of phase 9):
  - cycle_count increments and wraps at 2^CYC_W.
  - If continuous=1: phase=0, phase_start=1, stay in RUN.
  - If continuous=0: go to IDLE; the next edge sets phase=0, running=0, seq_done=1 (one cycle), phase_start=0.
- RUN -> PAUSED when pause=1: counter and phase hold, no phase_start. If pause rises on the last cycle of a phase, the advance is suppressed until resume.
- PAUSED -> RUN when pause=0; counting resumes from the held value.
- stop=1 in RUN or PAUSED:
  - Next edge: IDLE, phase=0, running=0, counter=0. No seq_done, no phase_start. cycle_count holds its value.
  - stop has priority over start, pause, and phase advance on the same cycle.
- start while RUN or PAUSED is ignored.
- Config writes:
  - cfg_we=1 in IDLE with cfg_addr<N_PHASES: dur[cfg_addr]<=cfg_data on the next edge; takes effect from the next start.
  - cfg_we while running, or with cfg_addr>=N_PHASES: write is dropped, and cfg_err=1 on the next cycle.
  - A write in the same cycle as a start is accepted, because state is still IDLE.
- Counter width: DUR_W bits. Compare against dur[phase]-1 (dwell 0 is forced to 1 first), so the counter never wraps.

Test Plan:
1. Reset, then read phase timing with defaults:
   - Program all dwells to 3 and pulse start with continuous=0.
   - Expect phase 0..9, each exactly 3 cycles, and phase_start every 3 cycles.
   - Expect seq_done pulse 30 cycles after the first phase_start, running=0, cycle_count=1.
2. Continuous mode, dwells 2, run 3 full sequences:
   - Expect phase to wrap 9->0 without a gap, cycle_count=3 after 60 cycles, and seq_done never asserted.
3. Pause and stop:
   - dwells 5; assert pause for 4 cycles in phase 2 at count 1. Expect phase 2 to last 9 cycles total.
   - Assert stop in phase 4. Next cycle: phase=0, running=0, no seq_done.
4. Config rules:
   - Write addr 12 in IDLE -> cfg_err pulse, table unchanged.
   - Write addr 3 while running -> cfg_err, and the phase 3 dwell stays at its old value.
   - Write addr 3 = 0 in IDLE -> phase 3 lasts 1 cycle.
5. Simultaneous events:
   - stop and start in the same IDLE cycle -> stays IDLE.
   - stop on the last cycle of Q9 with continuous=0 -> IDLE with no seq_done.
6. Async reset mid-phase 6:
   - Expect all outputs at reset values immediately and the dwell table restored (dur[2]=60000000 via a re-run with a cycle-count probe).
